// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter/sequencer in front of the single-port data memory.
//   Port 0 = CPU load/store unit, port 1 = debug/DMA loader. Each access is
//   sequenced IDLE -> ISSUE (gnt, memory command) -> RESP (reads only, rvalid).
//   A write takes 2 cycles per access and a read takes 3.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req/we/addr/wdata{0,1}   requester command, held stable until gnt
//   gnt{0,1}, err{0,1}       one-cycle accept pulse; err marks an out-of-range address
//   rvalid{0,1}, rdata{0,1}  read response; rdata is 0 whenever rvalid is low
//   we_DM, addDM, dataDM     memory command outputs
//   outDM                    memory registered read data
//   stat_gnt0/1, stat_conflict  16-bit saturating counters (tied to 0 by default)
// Build option: define DM_ARB_STATS_EN to implement the statistics counters.
module dm_arbiter #(
  parameter int unsigned AW    = 14,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned RR    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          err0,
  output logic          err1,
  output logic          we_DM,
  output logic [AW-1:0] addDM,
  output logic [DW-1:0] dataDM,
  input  logic [DW-1:0] outDM,
  output logic [15:0]   stat_gnt0,
  output logic [15:0]   stat_gnt1,
  output logic [15:0]   stat_conflict
);

  localparam int unsigned CW    = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam bit          RR_EN = (RR != 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t        r_state, w_state_nxt;

  logic          r_gnt0, r_gnt1, r_err0, r_err1, r_rvalid0, r_rvalid1;
  logic          r_we_dm, r_sel, r_we, r_oor, r_last;
  logic [AW-1:0] r_add;
  logic [DW-1:0] r_data;

  logic          w_gnt0, w_gnt1, w_err0, w_err1, w_rvalid0, w_rvalid1;
  logic          w_we_dm, w_sel, w_we, w_oor, w_last;
  logic [AW-1:0] w_add;
  logic [DW-1:0] w_data;

  logic          w_any_req, w_pick1, w_win_we, w_win_oor;
  logic [AW-1:0] w_win_addr;
  logic [DW-1:0] w_win_wdata;

  // Winner selection; r_last=1 means port 1 was granted most recently
  always_comb begin
    w_any_req = req0 | req1;
    w_pick1   = 1'b0;
    if (req1 && !req0) begin
      w_pick1 = 1'b1;
    end else if (req0 && req1) begin
      w_pick1 = RR_EN ? ~r_last : 1'b0;
    end
    w_win_we    = w_pick1 ? we1    : we0;
    w_win_addr  = w_pick1 ? addr1  : addr0;
    w_win_wdata = w_pick1 ? wdata1 : wdata0;
    w_win_oor   = ({1'b0, w_win_addr} >= DEPTH_C);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; writes skip RESP
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = r_we ? S_IDLE : S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and the captured command
  always_comb begin
    w_gnt0    = 1'b0;
    w_gnt1    = 1'b0;
    w_err0    = 1'b0;
    w_err1    = 1'b0;
    w_rvalid0 = 1'b0;
    w_rvalid1 = 1'b0;
    w_we_dm   = 1'b0;
    w_add     = r_add;
    w_data    = r_data;
    w_sel     = r_sel;
    w_we      = r_we;
    w_oor     = r_oor;
    w_last    = r_last;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_sel   = w_pick1;
          w_we    = w_win_we;
          w_oor   = w_win_oor;
          w_add   = w_win_addr;
          w_data  = w_win_wdata;
          // out-of-range writes are issued as harmless reads
          w_we_dm = w_win_we & ~w_win_oor;
          w_gnt0  = ~w_pick1;
          w_gnt1  = w_pick1;
          w_err0  = ~w_pick1 & w_win_oor;
          w_err1  = w_pick1 & w_win_oor;
          w_last  = w_pick1;
        end
      end
      S_ISSUE: begin
        if (!r_we) begin
          w_rvalid0 = ~r_sel;
          w_rvalid1 = r_sel;
        end
      end
      default: ;
    endcase
  end

  // Output and command registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_err0    <= 1'b0;
      r_err1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_we_dm   <= 1'b0;
      r_add     <= '0;
      r_data    <= '0;
      r_sel     <= 1'b0;
      r_we      <= 1'b0;
      r_oor     <= 1'b0;
      r_last    <= 1'b1;
    end else begin
      r_gnt0    <= w_gnt0;
      r_gnt1    <= w_gnt1;
      r_err0    <= w_err0;
      r_err1    <= w_err1;
      r_rvalid0 <= w_rvalid0;
      r_rvalid1 <= w_rvalid1;
      r_we_dm   <= w_we_dm;
      r_add     <= w_add;
      r_data    <= w_data;
      r_sel     <= w_sel;
      r_we      <= w_we;
      r_oor     <= w_oor;
      r_last    <= w_last;
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign err0    = r_err0;
  assign err1    = r_err1;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign we_DM   = r_we_dm;
  assign addDM   = r_add;
  assign dataDM  = r_data;

  // Memory read data arrives in RESP; out-of-range reads return 0
  assign rdata0 = (r_rvalid0 && !r_oor) ? outDM : '0;
  assign rdata1 = (r_rvalid1 && !r_oor) ? outDM : '0;

`ifdef DM_ARB_STATS_EN
  logic [15:0] r_stat_g0, r_stat_g1, r_stat_cf;
  logic        w_conflict;

  assign w_conflict = (r_state == S_IDLE) && req0 && req1;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_g0 <= '0;
      r_stat_g1 <= '0;
      r_stat_cf <= '0;
    end else begin
      if (r_gnt0 && r_stat_g0 != 16'hFFFF) r_stat_g0 <= r_stat_g0 + 16'd1;
      if (r_gnt1 && r_stat_g1 != 16'hFFFF) r_stat_g1 <= r_stat_g1 + 16'd1;
      if (w_conflict && r_stat_cf != 16'hFFFF) r_stat_cf <= r_stat_cf + 16'd1;
    end
  end

  assign stat_gnt0     = r_stat_g0;
  assign stat_gnt1     = r_stat_g1;
  assign stat_conflict = r_stat_cf;
`else
  assign stat_gnt0     = '0;
  assign stat_gnt1     = '0;
  assign stat_conflict = '0;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed bench for dm_arbiter with a behavioural 1024-word memory.
//   u_dut runs round-robin with the memory attached; u_fp runs fixed priority.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [13:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, we_dm;
  logic [31:0] rdata0, rdata1, data_dm, out_dm;
  logic [13:0] add_dm;
  logic [15:0] st_g0, st_g1, st_cf;

  logic        f_req0 = 1'b0, f_req1 = 1'b0;
  logic [31:0] f_zero = '0;
  logic        f_gnt0, f_gnt1, f_rv0, f_rv1, f_err0, f_err1, f_we_dm;
  logic [31:0] f_rd0, f_rd1, f_data_dm;
  logic [13:0] f_add_dm;
  logic [15:0] f_s0, f_s1, f_sc;

  int n_cmp = 0;
  int n_err = 0;
  int we_cnt = 0;

  dm_arbiter #(.AW(14), .DW(32), .DEPTH(1024), .RR(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .we_DM(we_dm), .addDM(add_dm), .dataDM(data_dm), .outDM(out_dm),
    .stat_gnt0(st_g0), .stat_gnt1(st_g1), .stat_conflict(st_cf)
  );

  dm_arbiter #(.AW(14), .DW(32), .DEPTH(1024), .RR(0)) u_fp (
    .clk(clk), .rst(rst),
    .req0(f_req0), .we0(1'b0), .addr0(14'd1), .wdata0(32'h0),
    .req1(f_req1), .we1(1'b0), .addr1(14'd2), .wdata1(32'h0),
    .gnt0(f_gnt0), .gnt1(f_gnt1), .rvalid0(f_rv0), .rvalid1(f_rv1),
    .rdata0(f_rd0), .rdata1(f_rd1), .err0(f_err0), .err1(f_err1),
    .we_DM(f_we_dm), .addDM(f_add_dm), .dataDM(f_data_dm), .outDM(f_zero),
    .stat_gnt0(f_s0), .stat_gnt1(f_s1), .stat_conflict(f_sc)
  );

  // Single-port memory: synchronous write, registered read when not writing
  logic [31:0] mem [0:1023];
  always_ff @(posedge clk) begin
    if (we_dm) mem[add_dm[9:0]] <= data_dm;
    else       out_dm <= mem[add_dm[9:0]];
  end

  // Count cycles in which the memory write enable is high
  always @(posedge clk) if (we_dm === 1'b1) we_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access on one port, checking latency, command outputs and response
  task automatic access(input string tag, input int port, input logic we,
                        input logic [13:0] addr, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd);
    int n;
    int we_base;
    logic g;
    @(negedge clk);
    if (port == 0) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    else           begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
    we_base = we_cnt;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      g = (port == 0) ? gnt0 : gnt1;
    end while (!g && n < 10);
    check_eq({tag, "_lat"}, 32'(n), 32'd1);
    check_eq({tag, "_err"}, 32'((port == 0) ? err0 : err1), 32'(exp_err));
    check_eq({tag, "_addDM"}, 32'(add_dm), 32'(addr));
    check_eq({tag, "_weDM"}, 32'(we_dm), 32'(we & ~exp_err));
    check_eq({tag, "_rd_idle"}, (port == 0) ? rdata0 : rdata1, 32'h0);
    if (we) check_eq({tag, "_dataDM"}, data_dm, wd);
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
    if (!we) begin
      @(negedge clk);
      check_eq({tag, "_rvalid"}, 32'((port == 0) ? rvalid0 : rvalid1), 32'd1);
      check_eq({tag, "_rvalid_oth"}, 32'((port == 0) ? rvalid1 : rvalid0), 32'd0);
      check_eq({tag, "_rdata"}, (port == 0) ? rdata0 : rdata1, exp_rd);
    end
    @(negedge clk);
    check_eq({tag, "_wecnt"}, 32'(we_cnt - we_base), 32'(we & ~exp_err));
  endtask

  // Both ports request concurrently; each drops req after its n-th grant
  task automatic run_pair(input string tag, input logic we,
                          input logic [13:0] a0, input logic [31:0] d0,
                          input logic [13:0] a1, input logic [31:0] d1,
                          input int n0_in, input int n1_in,
                          input logic [31:0] e0, input logic [31:0] e1,
                          output logic [3:0] order);
    int n0, n1, cyc, rv0, rv1;
    n0 = n0_in; n1 = n1_in; cyc = 0; rv0 = 0; rv1 = 0;
    order = 4'd0;
    @(negedge clk);
    req0 = 1'b1; we0 = we; addr0 = a0; wdata0 = d0;
    req1 = 1'b1; we1 = we; addr1 = a1; wdata1 = d1;
    while ((n0 > 0 || n1 > 0) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      check_eq({tag, "_excl"}, 32'(gnt0 & gnt1), 32'd0);
      if (rvalid0) begin rv0++; check_eq({tag, "_rd0"}, rdata0, e0); end
      if (rvalid1) begin rv1++; check_eq({tag, "_rd1"}, rdata1, e1); end
      if (gnt0) begin order = {order[2:0], 1'b0}; n0--; if (n0 == 0) req0 = 1'b0; end
      if (gnt1) begin order = {order[2:0], 1'b1}; n1--; if (n1 == 0) req1 = 1'b0; end
    end
    repeat (2) begin
      @(negedge clk);
      if (rvalid0) begin rv0++; check_eq({tag, "_rd0"}, rdata0, e0); end
      if (rvalid1) begin rv1++; check_eq({tag, "_rd1"}, rdata1, e1); end
    end
    req0 = 1'b0; req1 = 1'b0;
    check_eq({tag, "_done"}, 32'(cyc < 60), 32'd1);
    check_eq({tag, "_nrv0"}, 32'(rv0), we ? 32'd0 : 32'(n0_in));
    check_eq({tag, "_nrv1"}, 32'(rv1), we ? 32'd0 : 32'(n1_in));
  endtask

  initial begin
    logic [3:0] ord;
    int n, g0, g1;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
    check_eq("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
    check_eq("rst_err", 32'({err0, err1}), 32'd0);
    check_eq("rst_weDM", 32'(we_dm), 32'd0);
    check_eq("rst_addDM", 32'(add_dm), 32'd0);
    check_eq("rst_dataDM", data_dm, 32'd0);
    rst = 1'b0;

    // Basic write then read-back on port 0
    access("wr5", 0, 1'b1, 14'd5, 32'hDEADBEEF, 1'b0, 32'h0);
    access("rd5", 0, 1'b0, 14'd5, 32'h0, 1'b0, 32'hDEADBEEF);

    // Preload via port 1; last grant is then port 1
    access("pre1", 1, 1'b1, 14'd1, 32'h11, 1'b0, 32'h0);
    access("pre2", 1, 1'b1, 14'd2, 32'h22, 1'b0, 32'h0);

    // Round-robin with both ports reading twice
    run_pair("rr", 1'b0, 14'd1, 32'h0, 14'd2, 32'h0, 2, 2, 32'h11, 32'h22, ord);
    check_eq("rr_order", 32'(ord), 32'(4'b0101));

    // Out-of-range accesses; word 976 aliases 2000 in the low address bits
    access("pre976", 0, 1'b1, 14'd976, 32'hA5A5A5A5, 1'b0, 32'h0);
    access("oor_wr", 1, 1'b1, 14'd2000, 32'h12345678, 1'b1, 32'h0);
    access("oor_rd", 1, 1'b0, 14'd2000, 32'h0, 1'b1, 32'h0);
    access("chk976", 0, 1'b0, 14'd976, 32'h0, 1'b0, 32'hA5A5A5A5);
    access("top1023", 0, 1'b1, 14'd1023, 32'hCAFEF00D, 1'b0, 32'h0);
    access("top1024", 1, 1'b1, 14'd1024, 32'h0BADBAD0, 1'b1, 32'h0);

    // Reset during ISSUE of a port-0 read
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 14'd5;
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt0 && n < 10);
    check_eq("rstiss_lat", 32'(n), 32'd1);
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    check_eq("rstiss_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
    check_eq("rstiss_gnt", 32'({gnt0, gnt1, err0, err1}), 32'd0);
    check_eq("rstiss_weDM", 32'(we_dm), 32'd0);
    check_eq("rstiss_addDM", 32'(add_dm), 32'd0);
    check_eq("rstiss_dataDM", data_dm, 32'd0);
    check_eq("rstiss_rdata0", rdata0, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstiss_norv", 32'(rvalid0), 32'd0);
    access("post_wr", 1, 1'b1, 14'd3, 32'h00000077, 1'b0, 32'h0);
    access("post_rd", 1, 1'b0, 14'd3, 32'h0, 1'b0, 32'h00000077);

    // Statistics: 3 port-0 grants, 2 port-1 grants, 1 conflict cycle
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    run_pair("st", 1'b1, 14'd10, 32'h10, 14'd11, 32'h20, 1, 1, 32'h0, 32'h0, ord);
    check_eq("st_order", 32'(ord), 32'(4'b0001));
    access("st_a", 0, 1'b1, 14'd12, 32'h30, 1'b0, 32'h0);
    access("st_b", 0, 1'b1, 14'd13, 32'h40, 1'b0, 32'h0);
    access("st_c", 1, 1'b1, 14'd14, 32'h50, 1'b0, 32'h0);
    @(negedge clk);
`ifdef DM_ARB_STATS_EN
    check_eq("stat_gnt0", 32'(st_g0), 32'd3);
    check_eq("stat_gnt1", 32'(st_g1), 32'd2);
    check_eq("stat_conflict", 32'(st_cf), 32'd1);
`else
    check_eq("stat_gnt0", 32'(st_g0), 32'd0);
    check_eq("stat_gnt1", 32'(st_g1), 32'd0);
    check_eq("stat_conflict", 32'(st_cf), 32'd0);
`endif

    // Fixed priority: held requests on both ports only ever grant port 0
    @(negedge clk);
    f_req0 = 1'b1; f_req1 = 1'b1;
    g0 = 0; g1 = 0; n = 0;
    while (g0 < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (f_gnt0) g0++;
      if (f_gnt1) g1++;
    end
    f_req0 = 1'b0;
    check_eq("fp_gnt0", 32'(g0), 32'd4);
    check_eq("fp_gnt1", 32'(g1), 32'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!f_gnt1 && n < 8);
    check_eq("fp_gnt1_after", 32'(f_gnt1), 32'd1);
    f_req1 = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
